// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the kanade32 instruction/data memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned STARVE_W = 4;

  localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    MARB_IDLE = 2'd0,
    MARB_BUSY = 2'd1,
    MARB_RESP = 2'd2
  } marb_state_e;

  typedef enum logic {
    MARB_ID_IF = 1'b0,
    MARB_ID_D  = 1'b1
  } marb_id_e;

  // Request latched at grant time and presented on the memory port.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } marb_txn_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, data-stage and memory-port handshake bundle; slave is the arbiter side.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = mem_arbiter_pkg::ADDR_W,
  parameter int unsigned DATA_W = mem_arbiter_pkg::DATA_W
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_starve.sv
// Grant select (data priority) with a saturating fetch-starvation counter.
module mem_arb_starve
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     if_req,
  input  logic     d_req,
  input  logic     grant_en,
  output marb_id_e grant_id_c
);

  logic [STARVE_W-1:0] cnt_q;
  logic [STARVE_W-1:0] cnt_d;
  logic                fetch_due;

  // Fetch wins when alone or once data has been granted STARVE_MAX times over it.
  always_comb begin
    fetch_due  = (cnt_q == STARVE_W'(STARVE_MAX));
    grant_id_c = (if_req && (!d_req || fetch_due)) ? MARB_ID_IF : MARB_ID_D;
    cnt_d      = cnt_q;
    if (grant_en && (if_req || d_req)) begin
      if (grant_id_c == MARB_ID_D && if_req) begin
        cnt_d = cnt_q + STARVE_W'(1);
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and the data stage, one transaction at a time.
// Optional BUSY timeout with sticky err is enabled by KANADE_MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
`ifdef KANADE_MEM_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
  input  logic            clk,
  input  logic            rst,
  mem_arbiter_if.slave    bus,
  output logic            busy,
  output logic            err
);

`ifdef KANADE_MEM_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
`endif

  marb_state_e       state_q, state_d;
  marb_id_e          winner_q, winner_d;
  marb_id_e          grant_id_c;
  marb_txn_t         txn_q, txn_d;
  logic              mem_req_q, mem_req_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              busy_q, busy_d;
  logic              resp_fire;
  logic [DATA_W-1:0] resp_data;
`ifdef KANADE_MEM_ARB_TIMEOUT_EN
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              err_q, err_d;
`endif

  mem_arb_starve #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk        (clk),
    .rst        (rst),
    .if_req     (bus.if_req),
    .d_req      (bus.d_req),
    .grant_en   (state_q == MARB_IDLE),
    .grant_id_c (grant_id_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    winner_d   = winner_q;
    txn_d      = txn_q;
    mem_req_d  = mem_req_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    resp_fire  = 1'b0;
    resp_data  = bus.mem_rdata;
`ifdef KANADE_MEM_ARB_TIMEOUT_EN
    tmo_d      = tmo_q;
    err_d      = err_q;
`endif

    case (state_q)
      MARB_IDLE: begin
        if (bus.if_req || bus.d_req) begin
          winner_d  = grant_id_c;
          state_d   = MARB_BUSY;
          mem_req_d = 1'b1;
          if (grant_id_c == MARB_ID_IF) begin
            txn_d.we    = 1'b0;
            txn_d.addr  = bus.if_addr;
            txn_d.wdata = '0;
          end else begin
            txn_d.we    = bus.d_we;
            txn_d.addr  = bus.d_addr;
            txn_d.wdata = bus.d_wdata;
          end
`ifdef KANADE_MEM_ARB_TIMEOUT_EN
          tmo_d = '0;
`endif
        end
      end

      MARB_BUSY: begin
        if (bus.mem_ack) resp_fire = 1'b1;
`ifdef KANADE_MEM_ARB_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          resp_fire = 1'b1;
          resp_data = TIMEOUT_RDATA;
          err_d     = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
        // Write completions latch read data too; requesters ignore it.
        if (resp_fire) begin
          mem_req_d = 1'b0;
          state_d   = MARB_RESP;
          if (winner_q == MARB_ID_IF) begin
            if_rdata_d = resp_data;
            if_ack_d   = 1'b1;
          end else begin
            d_rdata_d  = resp_data;
            d_ack_d    = 1'b1;
          end
        end
      end

      MARB_RESP: state_d = MARB_IDLE;

      default: state_d = MARB_IDLE;
    endcase

    busy_d = (state_d != MARB_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MARB_IDLE;
      winner_q   <= MARB_ID_IF;
      txn_q      <= '0;
      mem_req_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef KANADE_MEM_ARB_TIMEOUT_EN
      tmo_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      winner_q   <= winner_d;
      txn_q      <= txn_d;
      mem_req_q  <= mem_req_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      busy_q     <= busy_d;
`ifdef KANADE_MEM_ARB_TIMEOUT_EN
      tmo_q      <= tmo_d;
      err_q      <= err_d;
`endif
    end
  end

  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = txn_q.we;
  assign bus.mem_addr  = txn_q.addr;
  assign bus.mem_wdata = txn_q.wdata;
  assign busy          = busy_q;
`ifdef KANADE_MEM_ARB_TIMEOUT_EN
  assign err           = err_q;
`else
  assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// checked cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int unsigned STARVE_MAX = 4;
`ifdef KANADE_MEM_ARB_TIMEOUT_EN
  localparam int unsigned TMO_CYC = 8;
`else
  localparam int unsigned TMO_CYC = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mem_arbiter_if bus ();

`ifdef KANADE_MEM_ARB_TIMEOUT_EN
  mem_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT_CYC(TMO_CYC)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .err(err));
`else
  mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .err(err));
`endif

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // Reference model: one transaction in flight, response cycle, starvation tally.
  bit          m_inflight, m_resp, m_win_if, m_read;
  int unsigned m_starve, m_bcyc;
  bit          e_mem_req, e_mem_we, e_if_ack, e_d_ack, e_busy, e_err;
  logic [31:0] e_mem_addr, e_mem_wdata, e_if_rdata, e_d_rdata;
  bit          if_valid, d_valid;

  // Stimulus knobs.
  int unsigned if_rate, d_rate, mem_lat;
  int          lat_fixed;
  bit          mem_fixed_en, stray_en;
  logic [31:0] mem_fixed;

  task automatic model_finish(input logic [31:0] val, input bit tmo);
    m_inflight = 1'b0;
    m_resp     = 1'b1;
    e_mem_req  = 1'b0;
    if (m_win_if) begin
      e_if_ack   = 1'b1;
      e_if_rdata = val;
      if_valid   = 1'b1;
    end else begin
      e_d_ack   = 1'b1;
      e_d_rdata = val;
      d_valid   = m_read || tmo;
    end
    if (tmo) e_err = 1'b1;
  endtask

  task automatic model_edge();
    if (rst) begin
      m_inflight = 0; m_resp = 0; m_starve = 0;
      e_mem_req = 0; e_mem_we = 0; e_mem_addr = '0; e_mem_wdata = '0;
      e_if_ack = 0; e_d_ack = 0; e_busy = 0; e_err = 0;
      e_if_rdata = '0; e_d_rdata = '0; if_valid = 1; d_valid = 1;
      return;
    end
    e_if_ack = 0;
    e_d_ack  = 0;
    if (m_resp) begin
      m_resp = 0;
    end else if (m_inflight) begin
      m_bcyc++;
      if (bus.mem_ack) model_finish(bus.mem_rdata, 1'b0);
      else if (TMO_CYC != 0 && m_bcyc == TMO_CYC) model_finish(32'hDEADBEEF, 1'b1);
    end else if (bus.if_req || bus.d_req) begin
      m_win_if = bus.if_req && (!bus.d_req || m_starve == STARVE_MAX);
      if (m_win_if || !bus.if_req) m_starve = 0;
      else m_starve++;
      m_inflight  = 1;
      m_bcyc      = 0;
      e_mem_req   = 1;
      m_read      = m_win_if || !bus.d_we;
      e_mem_we    = !m_win_if && bus.d_we;
      e_mem_addr  = m_win_if ? bus.if_addr : bus.d_addr;
      e_mem_wdata = m_win_if ? 32'h0 : bus.d_wdata;
    end
    e_busy = m_inflight || m_resp;
  endtask

  task automatic compare();
    chk("mem_req", 64'(bus.mem_req), 64'(e_mem_req));
    chk("busy",    64'(busy),        64'(e_busy));
    chk("if_ack",  64'(bus.if_ack),  64'(e_if_ack));
    chk("d_ack",   64'(bus.d_ack),   64'(e_d_ack));
    chk("err",     64'(err),         64'(e_err));
    if (e_mem_req) begin
      chk("mem_we",    64'(bus.mem_we),    64'(e_mem_we));
      chk("mem_addr",  64'(bus.mem_addr),  64'(e_mem_addr));
      chk("mem_wdata", 64'(bus.mem_wdata), 64'(e_mem_wdata));
    end
    if (if_valid) chk("if_rdata", 64'(bus.if_rdata), 64'(e_if_rdata));
    if (d_valid)  chk("d_rdata",  64'(bus.d_rdata),  64'(e_d_rdata));
  endtask

  // Requesters drop after their ack edge and may reissue; memory acks after mem_lat BUSY cycles.
  task automatic drive_next(input bit if_done, input bit d_done);
    if (if_done) bus.if_req = 1'b0;
    if (d_done)  bus.d_req  = 1'b0;
    if (!bus.if_req && if_rate != 0 && $urandom_range(99) < if_rate) begin
      bus.if_req  = 1'b1;
      bus.if_addr = $urandom;
    end
    if (!bus.d_req && d_rate != 0 && $urandom_range(99) < d_rate) begin
      bus.d_req   = 1'b1;
      bus.d_we    = 1'($urandom_range(1));
      bus.d_addr  = $urandom;
      bus.d_wdata = $urandom;
    end
    if (m_inflight && m_bcyc == 0) begin
      if (lat_fixed >= 0) mem_lat = 32'(lat_fixed);
      else mem_lat = ($urandom_range(9) == 0) ? 12 : $urandom_range(3);
    end
    if (m_inflight) bus.mem_ack = (m_bcyc == mem_lat);
    else            bus.mem_ack = stray_en && ($urandom_range(7) == 0);
    bus.mem_rdata = mem_fixed_en ? mem_fixed : $urandom;
  endtask

  task automatic step();
    bit if_done, d_done;
    if_done = e_if_ack;
    d_done  = e_d_ack;
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    compare();
    drive_next(if_done, d_done);
  endtask

  task automatic drain();
    bit done;
    done = 0;
    if_rate = 0;
    d_rate  = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      step();
      done = !bus.if_req && !bus.d_req && !e_busy;
    end
    chk("drain", 64'(done), 64'(1));
  endtask

  initial begin
    int n_busy, n_ack, hold_bad, seq, nd;
    bit seen;
    rst = 1'b1;
    bus.if_req = 0; bus.if_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_ack = 0; bus.mem_rdata = '0;
    if_rate = 0; d_rate = 0; lat_fixed = 0; mem_lat = 0;
    mem_fixed_en = 0; stray_en = 0; mem_fixed = '0;

    repeat (3) step();
    chk("rst_mem_addr",  64'(bus.mem_addr),  64'(0));
    chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'(0));
    chk("rst_mem_we",    64'(bus.mem_we),    64'(0));
    rst = 1'b0;
    step();

    // Single fetch read, minimum latency.
    lat_fixed = 0; mem_fixed_en = 1; mem_fixed = 32'h2402000A;
    bus.if_addr = 32'h100; bus.if_req = 1'b1;
    step();
    chk("a_mem_req",  64'(bus.mem_req),  64'(1));
    chk("a_mem_addr", 64'(bus.mem_addr), 64'(32'h100));
    chk("a_mem_we",   64'(bus.mem_we),   64'(0));
    step();
    chk("a_if_ack",   64'(bus.if_ack),   64'(1));
    chk("a_if_rdata", 64'(bus.if_rdata), 64'(32'h2402000A));
    chk("a_d_ack",    64'(bus.d_ack),    64'(0));
    step();
    mem_fixed_en = 0;

    // Data store with three wait cycles.
    lat_fixed = 3;
    bus.d_we = 1; bus.d_addr = 32'h40; bus.d_wdata = 32'h12345678; bus.d_req = 1;
    n_busy = 0; n_ack = 0; hold_bad = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.mem_req) begin
        n_busy++;
        if (bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'h12345678) hold_bad++;
      end
      if (bus.d_ack) n_ack++;
    end
    chk("b_busy_cycles", 64'(n_busy),   64'(4));
    chk("b_d_ack_count", 64'(n_ack),    64'(1));
    chk("b_hold",        64'(hold_bad), 64'(0));

    // Simultaneous requests: data first, then fetch.
    lat_fixed = 1; seq = 0;
    bus.if_addr = 32'h200; bus.if_req = 1;
    bus.d_we = 0; bus.d_addr = 32'h80; bus.d_req = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.d_ack)  seq = seq * 10 + 1;
      if (bus.if_ack) seq = seq * 10 + 2;
    end
    chk("c_order", 64'(seq), 64'(12));

    // Starvation: fetch held against back-to-back data.
    lat_fixed = 0; d_rate = 100;
    bus.if_addr = 32'h300; bus.if_req = 1;
    bus.d_we = 0; bus.d_addr = 32'h44; bus.d_wdata = '0; bus.d_req = 1;
    nd = 0; seen = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      step();
      if (bus.d_ack) nd++;
      if (bus.if_ack) seen = 1;
    end
    chk("d_fetch_seen",     64'(seen), 64'(1));
    chk("d_data_before_if", 64'(nd),   64'(STARVE_MAX));
    step();
    bus.if_addr = 32'h304; bus.if_req = 1;
    nd = 0; seen = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      step();
      if (bus.d_ack) nd++;
      if (bus.if_ack) seen = 1;
    end
    chk("d_data_after_clear", 64'(nd), 64'(STARVE_MAX));
    drain();

    // Reset during BUSY, then a stray memory ack.
    lat_fixed = 20;
    bus.d_we = 0; bus.d_addr = 32'h88; bus.d_req = 1;
    step();
    step();
    chk("e_busy_before", 64'(bus.mem_req), 64'(1));
    rst = 1;
    step();
    rst = 0;
    chk("e_mem_req_rst", 64'(bus.mem_req), 64'(0));
    bus.d_req = 0; bus.if_req = 0; bus.mem_ack = 1;
    n_ack = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      bus.mem_ack = 0;
      n_ack += int'(bus.if_ack) + int'(bus.d_ack) + int'(bus.mem_req) + int'(busy);
    end
    chk("e_quiet", 64'(n_ack), 64'(0));

`ifdef KANADE_MEM_ARB_TIMEOUT_EN
    // Memory never answers: abort after TMO_CYC BUSY cycles.
    lat_fixed = 50;
    bus.if_addr = 32'h500; bus.if_req = 1;
    n_busy = 0; seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      if (bus.mem_req) n_busy++;
      if (bus.if_ack) begin
        seen = 1;
        chk("f_rdata", 64'(bus.if_rdata), 64'(32'hDEADBEEF));
      end
    end
    chk("f_seen",       64'(seen),   64'(1));
    chk("f_req_cycles", 64'(n_busy), 64'(TMO_CYC));
    repeat (3) step();
    chk("f_err_sticky", 64'(err), 64'(1));
    rst = 1;
    step();
    rst = 0;
    chk("f_err_clear", 64'(err), 64'(0));
`endif

    // Random traffic with stray acks and varied memory latency.
    lat_fixed = -1; if_rate = 30; d_rate = 30; stray_en = 1;
    repeat (3000) step();
    stray_en = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single 32-bit memory port between instruction fetch and the data stage (decoder mem_read/mem_write path) of the kanade32 core. It accepts one request per requester, grants one at a time, sequences the request/ack handshake to memory, and returns read data with a one-cycle ack pulse. Data has priority; a starvation counter guarantees fetch progress.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_MAX, 4, consecutive data grants with fetch pending before fetch is forced (1..15)
TIMEOUT_CYC, 255, BUSY cycles before abort (used only with the optional feature)

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
if_req  in  1  fetch request, held with if_addr until if_ack
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetch read data, valid while if_ack=1
if_ack  out  1  one-cycle completion pulse to fetch
d_req  in  1  data request, held with d_we/d_addr/d_wdata until d_ack
d_we  in  1  1=write (sw), 0=read (lw)
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data, valid while d_ack=1
d_ack  out  1  one-cycle completion pulse to data stage
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
mem_ack  in  1  memory completion, single-cycle
busy  out  1  high in BUSY and RESP
err  out  1  sticky timeout flag (0 when feature disabled)

Behaviour:
- Reset: state IDLE; all outputs 0; starvation count 0; grant register = fetch. Reset mid-transaction abandons it: mem_req low from the next edge, no ack issued, any later mem_ack ignored.
- States: IDLE, BUSY, RESP. All outputs registered.
- IDLE: if d_req or if_req, arbitrate; latch winner id, addr, we (0 for fetch), wdata (0 for fetch) into mem_* registers; next state BUSY. Otherwise stay.
- Arbitration: data wins unless if_req=1 and starve count==STARVE_MAX, then fetch wins. Count increments on a data grant with if_req=1; clears on fetch grant or data grant with if_req=0. Saturates at STARVE_MAX.
- BUSY: mem_req=1, mem_* stable. On mem_ack: latch mem_rdata into winner's rdata register (writes latch too, value don't-care), drop mem_req, next RESP. Requester inputs ignored while BUSY.
- RESP: winner's ack=1 for exactly this cycle; other ack 0; next IDLE. The edge on which a requester samples ack=1 completes its transaction; req seen in the following IDLE cycle is a new request (back-to-back allowed).
- Minimum latency: req sampled in IDLE cycle n, mem_req high n+1, mem_ack at n+1 gives ack at n+2. No upper bound without the optional feature.
- mem_ack in IDLE or RESP is ignored. if_rdata/d_rdata hold last value outside ack.

Optional Feature:
KANADE_MEM_ARB_TIMEOUT_EN: adds a BUSY cycle counter (clears entering BUSY). When it reaches TIMEOUT_CYC without mem_ack: drop mem_req, winner rdata = 32'hDEADBEEF, go RESP (ack issued), set err sticky until rst. Without the macro: no counter, BUSY waits indefinitely, err tied 0.

Decomposition:
- State encodings (MARB_IDLE/BUSY/RESP) and requester ids (MARB_ID_IF, MARB_ID_D) as macros in include/define.v alongside the ALU_OP_* constants.
- One sub-module natural: mem_arb_starve, the saturating starvation counter plus grant-select logic (inputs if_req, d_req, grant_en; output grant id).

Test Plan:
- Single fetch read: if_req, if_addr=0x100, memory acks 1 cycle later with 0x2402000A -> mem_addr=0x100, mem_we=0, if_ack pulse at n+2, if_rdata=0x2402000A, d_ack stays 0.
- Data store: d_req, d_we=1, d_addr=0x40, d_wdata=0x12345678, ack after 3 wait cycles -> mem_we=1, mem_wdata=0x12345678 held all BUSY cycles, one d_ack pulse.
- Simultaneous: if_req and d_req both high in IDLE -> data granted first, fetch granted on the next IDLE, two distinct ack pulses.
- Starvation: if_req held, d_req issuing back-to-back, STARVE_MAX=4 -> 4 data grants, then fetch grant, count clears.
- Reset mid-BUSY: rst for 1 cycle during BUSY, then stray mem_ack -> mem_req 0, busy 0, no if_ack/d_ack.
- With KANADE_MEM_ARB_TIMEOUT_EN, TIMEOUT_CYC=8, no mem_ack -> mem_req drops after 8 BUSY cycles, ack with rdata 0xDEADBEEF, err=1 until rst.
